// File: rtl/fetch_unit_pkg.sv
// Shared IF-stage types: IF_ID pipeline register payload, fetch FSM states, bubble word.
package pipeline_stage_registers;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] fetched_inst;
    logic [XLEN-1:0] pc;
    logic            do_not_execute;
  } IF_ID;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_t;

  function automatic IF_ID make_if_id(input logic [XLEN-1:0] inst,
                                      input logic [XLEN-1:0] pc,
                                      input logic            dne);
    IF_ID v;
    v.fetched_inst   = inst;
    v.pc             = pc;
    v.do_not_execute = dne;
    return v;
  endfunction

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// Single-entry {inst, pc} holding slot for a response that arrived while decode was stalled.
module fetch_skid_buffer
  import pipeline_stage_registers::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  logic            r_full;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;

  // Clear (redirect) wins over load so a squashed response never lingers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full <= 1'b0;
      r_inst <= '0;
      r_pc   <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, IF_ID register to decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipeline_stage_registers::NOP_INST
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  output logic                            imem_req_valid,
  output logic [31:0]                     imem_req_addr,
  input  logic                            imem_req_ready,
  input  logic                            imem_resp_valid,
  input  logic [31:0]                     imem_resp_data,
  output pipeline_stage_registers::IF_ID  if_id_reg,
  output logic                            fetch_fault
);

  import pipeline_stage_registers::*;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  IF_ID            r_if_id;
  logic            r_fault;

  logic            w_req_fire;
  logic            w_misaligned;
  fetch_state_t    w_redirect_state;
  IF_ID            w_bubble;
  logic            w_skid_load;
  logic            w_skid_pop;
  logic            w_skid_full;
  logic [XLEN-1:0] w_skid_inst;
  logic [XLEN-1:0] w_skid_pc;

  assign imem_req_valid   = (r_state == FETCH) && !redirect_valid && !reset;
  assign imem_req_addr    = r_pc;
  assign w_req_fire       = imem_req_valid && imem_req_ready;
  assign w_misaligned     = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_state = w_misaligned ? FAULT : FETCH;
  assign w_bubble         = make_if_id(NOP_INST, r_pc, 1'b1);

  // Skid traffic only happens on the non-redirect path; redirect clears it instead.
  assign w_skid_load = !reset && !redirect_valid && (r_state == WAIT) && imem_resp_valid && stall;
  assign w_skid_pop  = !reset && !redirect_valid && (r_state == HOLD) && !stall;

  fetch_skid_buffer u_skid (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_clear (redirect_valid),
    .i_inst  (imem_resp_data),
    .i_pc    (r_req_pc),
    .o_full  (w_skid_full),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_if_id  <= make_if_id(NOP_INST, '0, 1'b1);
      r_fault  <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect overrides stall; an outstanding request must still be drained.
      r_if_id <= w_bubble;
      r_pc    <= redirect_pc;
      r_fault <= w_misaligned;
      unique case (r_state)
        WAIT, DRAIN: r_state <= imem_resp_valid ? w_redirect_state : DRAIN;
        default:     r_state <= w_redirect_state;
      endcase
    end else begin
      unique case (r_state)
        FETCH: begin
          if (!stall) r_if_id <= w_bubble;
          if (w_req_fire) begin
            r_req_pc <= r_pc;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            r_pc <= r_req_pc + PC_STEP;
            if (stall) begin
              r_state <= HOLD;
            end else begin
              r_if_id <= make_if_id(imem_resp_data, r_req_pc, 1'b0);
              r_state <= FETCH;
            end
          end else if (!stall) begin
            r_if_id <= w_bubble;
          end
        end
        HOLD: begin
          if (!stall) begin
            r_if_id <= w_skid_full ? make_if_id(w_skid_inst, w_skid_pc, 1'b0) : w_bubble;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (!stall) r_if_id <= w_bubble;
          if (imem_resp_valid) r_state <= r_fault ? FAULT : FETCH;
        end
        FAULT: begin
          if (!stall) r_if_id <= w_bubble;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign if_id_reg   = r_if_id;
  assign fetch_fault = r_fault;

endmodule
